// File: rtl/hdb3_pkg.sv
// Shared HDB3 symbol codes and run-length constants, common to the
// violation/balancing insertion stage and the downstream polarity stage.
package hdb3_pkg;

   localparam logic [1:0] CODE_ZERO = 2'b00;
   localparam logic [1:0] CODE_ONE  = 2'b01;
   localparam logic [1:0] CODE_V    = 2'b10;
   localparam logic [1:0] CODE_B    = 2'b11;

   // Length of the zero run that gets substituted (000V / B00V).
   localparam int ZERO_RUN = 4;

   // Zero count at which the next zero completes a run.
   localparam logic [1:0] ZCNT_LAST = 2'(ZERO_RUN - 1);
   // Delay line is primed once ZERO_RUN symbols have been shifted in.
   localparam logic [2:0] FILL_FULL = 3'(ZERO_RUN);

endpackage

// File: rtl/hdb3_vb_insert.sv
// HDB3 violation/balancing insertion. Delays the NRZ stream through a
// four-deep symbol line so a run of four zeros can be rewritten as 000V
// or B00V once the fourth zero arrives, choosing B when the pulse count
// since the last V is even. Codes feed the polarity stage's datain_b.
module hdb3_vb_insert
   import hdb3_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic       data_in,
   output logic       out_valid,
   output logic [1:0] code_out
);

   logic [1:0] r_s0, r_s1, r_s2, r_s3;
   logic [1:0] r_zcnt;
   logic       r_par;
   logic [2:0] r_fill;
   logic       r_out_valid;

   logic       w_run_end;
   logic [2:0] w_fill_nxt;

   // Fourth consecutive zero: this beat closes a substitution run.
   assign w_run_end  = ~data_in && (r_zcnt == ZCNT_LAST);
   assign w_fill_nxt = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 3'd1;

   // Symbol delay line with B/V rewrite applied as the run's first zero reaches s3.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s0 <= CODE_ZERO;
         r_s1 <= CODE_ZERO;
         r_s2 <= CODE_ZERO;
         r_s3 <= CODE_ZERO;
      end else if (in_valid) begin
         r_s1 <= r_s0;
         r_s2 <= r_s1;
         if (w_run_end) begin
            r_s0 <= CODE_V;
            r_s3 <= r_par ? r_s2 : CODE_B;
         end else begin
            r_s0 <= data_in ? CODE_ONE : CODE_ZERO;
            r_s3 <= r_s2;
         end
      end
   end

   // Zero-run length and pulse parity since the last V.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_zcnt <= 2'd0;
         r_par  <= 1'b0;
      end else if (in_valid) begin
         if (data_in) begin
            r_zcnt <= 2'd0;
            r_par  <= ~r_par;
         end else if (w_run_end) begin
            r_zcnt <= 2'd0;
            r_par  <= 1'b0;
         end else begin
            r_zcnt <= r_zcnt + 2'd1;
         end
      end
   end

   // Prime counter and one-cycle output strobe once the line holds real symbols.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fill      <= 3'd0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid && (w_fill_nxt == FILL_FULL);
         if (in_valid) r_fill <= w_fill_nxt;
      end
   end

   assign code_out  = r_s3;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_hdb3_vb_insert.sv
// Bench for hdb3_vb_insert: directed streams from the HDB3 examples plus a
// randomized run, all checked against a symbol-list reference model.
module tb_hdb3_vb_insert;
   import hdb3_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       in_valid;
   logic       data_in;
   logic       out_valid;
   logic [1:0] code_out;

   int vectors;
   int miscompares;

   // Reference model: the full encoded symbol stream since reset.
   logic [1:0] sym[$];
   int         zrun;
   int         pulses;
   logic [1:0] got[$];

   hdb3_vb_insert dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .code_out  (code_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_clear();
      sym.delete();
      zrun   = 0;
      pulses = 0;
   endtask

   // Append one NRZ bit; on the fourth zero rewrite the run as 000V or B00V.
   task automatic model_push(input logic b);
      if (b) begin
         sym.push_back(CODE_ONE);
         pulses++;
         zrun = 0;
      end else begin
         sym.push_back(CODE_ZERO);
         zrun++;
         if (zrun == 4) begin
            if (pulses % 2 == 0) sym[sym.size()-4] = CODE_B;
            sym[sym.size()-1] = CODE_V;
            pulses = 0;
            zrun   = 0;
         end
      end
   endtask

   // One clock: drive, let the edge pass, then compare against the model.
   task automatic step(input logic v, input logic d, input string tag);
      int n;
      logic [1:0] exp_code;
      in_valid = v;
      data_in  = d;
      @(posedge clk);
      if (v) model_push(d);
      #1;
      n = sym.size();
      exp_code = (n >= 4) ? sym[n-4] : CODE_ZERO;
      chk({tag, "_vld"}, {1'b0, out_valid}, {1'b0, v && (n >= 4)});
      chk({tag, "_code"}, code_out, exp_code);
      if (out_valid) got.push_back(code_out);
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      reset_n  = 1'b0;
      in_valid = 1'b0;
      data_in  = 1'b0;
      model_clear();
      #1;
      chk("rst_async_code", code_out, CODE_ZERO);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         chk("rst_vld", {1'b0, out_valid}, 2'b00);
         chk("rst_code", code_out, CODE_ZERO);
      end
      reset_n = 1'b1;
      got.delete();
   endtask

   task automatic stream(input logic [31:0] bits, input int len, input string tag);
      for (int i = len - 1; i >= 0; i--) step(1'b1, bits[i], tag);
   endtask

   task automatic cmp_got(input logic [1:0] exp_q[$], input string tag);
      chk({tag, "_count"}, 2'(got.size() == exp_q.size()), 2'd1);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk({tag, "_sym"}, got[i], exp_q[i]);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      data_in     = 1'b0;
      model_clear();

      // Ones only: straight marks, first strobe after the 4th beat.
      do_reset(2);
      stream(32'b11111, 5, "ones");
      cmp_got('{CODE_ONE, CODE_ONE}, "ones");

      // Four zeros from reset: even parity gives B00V.
      do_reset(2);
      stream(32'b0000_111, 7, "b00v");
      cmp_got('{CODE_B, CODE_ZERO, CODE_ZERO, CODE_V}, "b00v");

      // One mark then four zeros: odd parity gives 000V.
      do_reset(2);
      stream(32'b1_0000_111, 8, "000v");
      cmp_got('{CODE_ONE, CODE_ZERO, CODE_ZERO, CODE_ZERO, CODE_V}, "000v");

      // Eight zeros after two marks: two independent runs, both B00V.
      do_reset(2);
      stream(32'b11_0000_0000_111_111, 16, "two_runs");
      cmp_got('{CODE_ONE, CODE_ONE, CODE_B, CODE_ZERO, CODE_ZERO, CODE_V,
                CODE_B, CODE_ZERO, CODE_ZERO, CODE_V, CODE_ONE, CODE_ONE,
                CODE_ONE}, "two_runs");

      // Stall inside a zero run: no strobes, same symbols.
      do_reset(2);
      stream(32'b00, 2, "stall_a");
      repeat (5) step(1'b0, 1'b1, "stall_idle");
      stream(32'b00_111, 5, "stall_b");
      cmp_got('{CODE_B, CODE_ZERO, CODE_ZERO, CODE_V}, "stall");

      // Reset mid-run discards the partial run and the parity.
      do_reset(2);
      stream(32'b1000, 4, "mid_a");
      do_reset(2);
      stream(32'b0000_1_111, 8, "mid_b");
      cmp_got('{CODE_B, CODE_ZERO, CODE_ZERO, CODE_V, CODE_ONE}, "mid");

      // Randomized: sparse ones, gaps in in_valid, occasional reset.
      do_reset(1);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute bound so the run always terminates.
   initial begin
      #500000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
